// File: rtl/cart_loader.sv
// Cartridge download loader: buffers hps_io ioctl bytes in a small FIFO, writes them
// to SDRAM over valid/ready, and derives the cartridge descriptors for cv_console.
module cart_loader #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 25
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              ioctl_download_i,
   input  logic [7:0]        ioctl_index_i,
   input  logic              ioctl_wr_i,
   input  logic [ADDR_W-1:0] ioctl_addr_i,
   input  logic [7:0]        ioctl_dout_i,
   output logic              ioctl_wait_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_din_o,
   output logic              mem_we_o,
   input  logic              mem_ready_i,
   output logic [5:0]        cart_pages_o,
   output logic              sg1000_o,
   output logic              extram_o,
   output logic              header_ok_o,
   output logic              overflow_o,
   output logic              busy_o,
   output logic              load_done_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [EW-1:0] r_fifo [FIFO_DEPTH];
   logic [CW-1:0] r_wr_ptr, r_rd_ptr;
   logic          r_wait;
   logic [5:0]    r_pages;
   logic          r_sg1000, r_extram, r_header_ok, r_overflow;
   logic [7:0]    r_byte0;
   logic [1:0]    r_state;

   logic [CW-1:0] w_count, w_count_nxt;
   logic          w_full, w_empty, w_push, w_pop;
   logic [EW-1:0] w_head;
   logic          w_in_window, w_hdr_match;
   logic [15:0]   w_hdr;
   logic [1:0]    w_state_nxt;
   logic          w_unused_idx;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_full      = (w_count == CW'(FIFO_DEPTH));
   assign w_empty     = (w_count == '0);
   assign w_push      = ioctl_wr_i & ~w_full;
   assign w_pop       = ~w_empty & mem_ready_i;
   assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
   assign w_head      = r_fifo[r_rd_ptr[PW-1:0]];

   assign mem_we_o   = ~w_empty;
   assign mem_addr_o = w_empty ? '0 : w_head[EW-1:8];
   assign mem_din_o  = w_empty ? '0 : w_head[7:0];

   // NOTE: the storage array is not reset; the pointers define which entries are
   // valid and the memory outputs are masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= {ioctl_addr_i, ioctl_dout_i};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_wait   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_wait <= (w_count_nxt >= CW'(FIFO_DEPTH - 1));
      end
   end

   assign w_in_window  = r_sg1000 && (ioctl_addr_i[ADDR_W-1:13] == (ADDR_W-13)'(1));
   assign w_hdr        = {r_byte0, ioctl_dout_i};
   assign w_hdr_match  = (w_hdr == 16'hAA55) || (w_hdr == 16'h55AA);
   assign w_unused_idx = ^ioctl_index_i[7:5];

   // Descriptors track the push side only; a dropped byte touches nothing but overflow.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_pages     <= '0;
         r_sg1000    <= 1'b0;
         r_extram    <= 1'b0;
         r_header_ok <= 1'b0;
         r_overflow  <= 1'b0;
         r_byte0     <= '0;
      end else begin
         if (ioctl_wr_i && w_full) r_overflow <= 1'b1;
         if (w_push) begin
            r_pages <= ioctl_addr_i[19:14];
            if (ioctl_addr_i == '0) begin
               r_sg1000    <= (ioctl_index_i[4:0] == 5'd2);
               r_extram    <= 1'b0;
               r_header_ok <= 1'b0;
               r_overflow  <= 1'b0;
               r_byte0     <= ioctl_dout_i;
            end
            if (ioctl_addr_i == ADDR_W'(1)) r_header_ok <= w_hdr_match && !r_sg1000;
            if (w_in_window)
               r_extram <= ((ioctl_addr_i[12:0] == 13'd0) | r_extram) & (ioctl_dout_i == 8'hFF);
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (ioctl_download_i) w_state_nxt = ST_LOAD;
         ST_LOAD:  if (!ioctl_download_i) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (w_empty)               w_state_nxt = ST_DONE;
            else if (ioctl_download_i) w_state_nxt = ST_LOAD;
         end
         default:  w_state_nxt = ioctl_download_i ? ST_LOAD : ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   assign ioctl_wait_o = r_wait;
   assign cart_pages_o = r_pages;
   assign sg1000_o     = r_sg1000;
   assign extram_o     = r_extram;
   assign header_ok_o  = r_header_ok;
   assign overflow_o   = r_overflow;
   assign busy_o       = (r_state != ST_IDLE);
   assign load_done_o  = (r_state == ST_DONE);

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: drives ioctl bytes, scoreboards SDRAM writes
// against the bytes it pushed, and checks descriptors, back-pressure and the FSM.
module tb_cart_loader;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b1;
   logic        ioctl_download_i = 1'b0;
   logic [7:0]  ioctl_index_i = '0;
   logic        ioctl_wr_i = 1'b0;
   logic [24:0] ioctl_addr_i = '0;
   logic [7:0]  ioctl_dout_i = '0;
   logic        ioctl_wait_o;
   logic [24:0] mem_addr_o;
   logic [7:0]  mem_din_o;
   logic        mem_we_o;
   logic        mem_ready_i = 1'b0;
   logic [5:0]  cart_pages_o;
   logic        sg1000_o, extram_o, header_ok_o, overflow_o, busy_o, load_done_o;

   typedef struct packed {
      logic [24:0] a;
      logic [7:0]  d;
   } ent_t;

   ent_t        exp_q[$];
   int          n_checks = 0;
   int          n_err = 0;
   int          n_wr = 0;
   logic        stalled = 1'b0;
   logic [24:0] st_addr = '0;
   logic [7:0]  st_data = '0;

   cart_loader #(.FIFO_DEPTH(4), .ADDR_W(25)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .ioctl_download_i(ioctl_download_i), .ioctl_index_i(ioctl_index_i),
      .ioctl_wr_i(ioctl_wr_i), .ioctl_addr_i(ioctl_addr_i), .ioctl_dout_i(ioctl_dout_i),
      .ioctl_wait_o(ioctl_wait_o),
      .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_we_o(mem_we_o),
      .mem_ready_i(mem_ready_i),
      .cart_pages_o(cart_pages_o), .sg1000_o(sg1000_o), .extram_o(extram_o),
      .header_ok_o(header_ok_o), .overflow_o(overflow_o), .busy_o(busy_o),
      .load_done_o(load_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accepted writes must match pushed bytes in order; stalled heads must not move.
   always @(posedge clk_i) begin
      if (!reset_n_i) begin
         stalled <= 1'b0;
      end else begin
         if (stalled) begin
            check("stall_we", mem_we_o, 1);
            check("stall_addr", mem_addr_o, st_addr);
            check("stall_data", mem_din_o, st_data);
         end
         if (mem_we_o && mem_ready_i) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               check("wr_addr", mem_addr_o, exp_q[0].a);
               check("wr_data", mem_din_o, exp_q[0].d);
               void'(exp_q.pop_front());
            end
         end
         stalled <= mem_we_o && !mem_ready_i;
         st_addr <= mem_addr_o;
         st_data <= mem_din_o;
      end
   end

   task automatic push(input logic [24:0] pa, input logic [7:0] pd);
      ioctl_wr_i   = 1'b1;
      ioctl_addr_i = pa;
      ioctl_dout_i = pd;
      exp_q.push_back('{a: pa, d: pd});
      @(negedge clk_i);
      ioctl_wr_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wait"}, ioctl_wait_o, 0);
      check({tag, "_maddr"}, mem_addr_o, 0);
      check({tag, "_mdin"}, mem_din_o, 0);
      check({tag, "_mwe"}, mem_we_o, 0);
      check({tag, "_pages"}, cart_pages_o, 0);
      check({tag, "_sg"}, sg1000_o, 0);
      check({tag, "_ext"}, extram_o, 0);
      check({tag, "_hdr"}, header_ok_o, 0);
      check({tag, "_ovf"}, overflow_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, load_done_o, 0);
   endtask

   // Called just after download falls; exp_cyc < 0 skips the latency comparison.
   task automatic wait_done(input int exp_cyc);
      int cyc = 0;
      while (!load_done_o && cyc < 200) begin
         @(negedge clk_i);
         cyc++;
      end
      check("done_seen", load_done_o, 1);
      if (exp_cyc >= 0) check("done_latency", cyc, exp_cyc);
      @(negedge clk_i);
      check("done_one_cycle", load_done_o, 0);
      check("idle_after_done", busy_o, 0);
   endtask

   task automatic run_coleco();
      int base = n_wr;
      ioctl_index_i    = 8'd0;
      mem_ready_i      = 1'b1;
      ioctl_download_i = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < 16; i++)
         push(25'(i), (i == 0) ? 8'hAA : (i == 1) ? 8'h55 : 8'(i * 3 + 1));
      ioctl_download_i = 1'b0;
      wait_done(2);
      check("col_writes", n_wr - base, 16);
      check("col_queue_empty", exp_q.size(), 0);
      check("col_header_ok", header_ok_o, 1);
      check("col_sg1000", sg1000_o, 0);
      check("col_pages", cart_pages_o, 0);
   endtask

   task automatic run_sg(input logic [7:0] b3000, input logic exp_ext);
      ioctl_index_i    = 8'd2;
      mem_ready_i      = 1'b1;
      ioctl_download_i = 1'b1;
      @(negedge clk_i);
      push(25'h0, 8'hAA);
      check("sg_ext_cleared", extram_o, 0);
      check("sg_flag_set", sg1000_o, 1);
      push(25'h1, 8'h55);
      for (int a = 'h2000; a <= 'h3FFF; a++)
         push(25'(a), (a == 'h3000) ? b3000 : 8'hFF);
      push(25'h7FFF, 8'h5A);
      ioctl_download_i = 1'b0;
      wait_done(-1);
      check("sg_sg1000", sg1000_o, 1);
      check("sg_extram", extram_o, exp_ext);
      check("sg_pages", cart_pages_o, 1);
      check("sg_header_ok", header_ok_o, 0);
      check("sg_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int sent;
      int cyc;

      #1 reset_n_i = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk_i);
      check_all_zero("reset_clk");
      reset_n_i = 1'b1;
      @(negedge clk_i);

      run_coleco();

      run_sg(8'hFF, 1'b1);
      run_sg(8'h00, 1'b0);

      // Stalled SDRAM: four bytes fill the FIFO, the fifth meets a simultaneous pop.
      base             = n_wr;
      ioctl_index_i    = 8'd0;
      mem_ready_i      = 1'b0;
      ioctl_download_i = 1'b1;
      @(negedge clk_i);
      push(25'h0, 8'h11);
      check("ovf_wait_after_1", ioctl_wait_o, 0);
      push(25'h1, 8'h22);
      check("ovf_wait_after_2", ioctl_wait_o, 0);
      push(25'h2, 8'h33);
      check("ovf_wait_after_3", ioctl_wait_o, 1);
      push(25'h3, 8'h44);
      check("ovf_head_we", mem_we_o, 1);
      check("ovf_head_addr", mem_addr_o, 0);
      check("ovf_head_data", mem_din_o, 8'h11);
      check("ovf_no_flag_yet", overflow_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      check("ovf_no_write_stalled", n_wr - base, 0);
      ioctl_wr_i   = 1'b1;
      ioctl_addr_i = 25'h0C004;
      ioctl_dout_i = 8'h55;
      mem_ready_i  = 1'b1;
      @(negedge clk_i);
      ioctl_wr_i = 1'b0;
      check("ovf_set", overflow_o, 1);
      check("ovf_pages_unchanged", cart_pages_o, 0);
      ioctl_download_i = 1'b0;
      wait_done(-1);
      check("ovf_writes", n_wr - base, 4);
      check("ovf_queue_empty", exp_q.size(), 0);
      check("ovf_sticky", overflow_o, 1);
      check("ovf_wait_clear", ioctl_wait_o, 0);

      // Ready toggling every cycle; the host honours ioctl_wait.
      base             = n_wr;
      sent             = 0;
      cyc              = 0;
      ioctl_download_i = 1'b1;
      mem_ready_i      = 1'b0;
      @(negedge clk_i);
      while (sent < 64 && cyc < 1000) begin
         mem_ready_i = ~mem_ready_i;
         if (!ioctl_wait_o) begin
            ioctl_wr_i   = 1'b1;
            ioctl_addr_i = 25'(sent);
            ioctl_dout_i = (sent == 0) ? 8'h55 : (sent == 1) ? 8'hAA : 8'(sent * 5 + 7);
            exp_q.push_back('{a: 25'(sent), d: ioctl_dout_i});
            sent++;
         end else begin
            ioctl_wr_i = 1'b0;
         end
         @(negedge clk_i);
         cyc++;
      end
      ioctl_wr_i = 1'b0;
      check("tog_all_sent", sent, 64);
      check("tog_ovf_cleared", overflow_o, 0);
      mem_ready_i      = 1'b1;
      ioctl_download_i = 1'b0;
      wait_done(-1);
      check("tog_writes", n_wr - base, 64);
      check("tog_queue_empty", exp_q.size(), 0);
      check("tog_header_55aa", header_ok_o, 1);
      check("tog_pages", cart_pages_o, 0);

      // Header 55,55 is not a Coleco signature.
      ioctl_download_i = 1'b1;
      @(negedge clk_i);
      push(25'h0, 8'h55);
      push(25'h1, 8'h55);
      ioctl_download_i = 1'b0;
      wait_done(-1);
      check("hdr_5555", header_ok_o, 0);

      // Reset while draining a stalled FIFO.
      mem_ready_i      = 1'b0;
      ioctl_download_i = 1'b1;
      @(negedge clk_i);
      push(25'h0, 8'hAA);
      push(25'h1, 8'h55);
      push(25'h2, 8'h01);
      ioctl_download_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_pre_busy", busy_o, 1);
      check("rst_pre_we", mem_we_o, 1);
      check("rst_pre_hdr", header_ok_o, 1);
      #2 reset_n_i = 1'b0;
      #1 check_all_zero("rst_async");
      exp_q.delete();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      check_all_zero("rst_after");

      run_coleco();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits between hps_io's ioctl download stream and the SDRAM cartridge store.
- Buffers incoming ROM bytes in a small FIFO and writes them to SDRAM over a valid/ready handshake.
- Applies back-pressure to the HPS through ioctl_wait.
- Derives the cartridge descriptors consumed by cv_console: page count, SG-1000 mode, SG-1000 extra-RAM detect, and Coleco header validity.

Parameters:
- FIFO_DEPTH, 4, FIFO entries (power of two, ≥2).
- ADDR_W, 25, ioctl/SDRAM byte address width.

Ports:
- clk_i  in  1  system clock (clk_sys).
- reset_n_i  in  1  asynchronous active-low reset.
- ioctl_download_i  in  1  download active.
- ioctl_index_i  in  8  file index; [4:0]==2 means SG-1000 image.
- ioctl_wr_i  in  1  byte strobe, one cycle per byte.
- ioctl_addr_i  in  ADDR_W  byte address.
- ioctl_dout_i  in  8  byte data.
- ioctl_wait_o  out  1  back-pressure to HPS.
- mem_addr_o  out  ADDR_W  SDRAM write address.
- mem_din_o  out  8  SDRAM write data.
- mem_we_o  out  1  write request (valid).
- mem_ready_i  in  1  SDRAM accepts the write this cycle.
- cart_pages_o  out  6  last accepted ioctl_addr[19:14].
- sg1000_o  out  1  SG-1000 image loaded.
- extram_o  out  1  SG-1000 image with 0x2000-0x3FFF entirely 0xFF.
- header_ok_o  out  1  bytes 0/1 are AA,55 or 55,AA.
- overflow_o  out  1  sticky: byte dropped while FIFO full.
- busy_o  out  1  state != IDLE.
- load_done_o  out  1  one-cycle pulse when the last byte is committed.

Behaviour:

Reset:
- Every output is 0, the FIFO is empty and the FSM is in IDLE.
- Reset mid-download discards FIFO contents. The write in flight is abandoned.

FIFO push:
- A push happens when ioctl_wr_i=1 and the FIFO is not full. It stores {addr, data}.
- ioctl_wr_i while full: the byte is dropped, overflow_o is set, and no flag update occurs.
- Simultaneous push and pop while full: the push is still rejected, because full is evaluated before the pop.
- ioctl_wait_o is registered, =1 when occupancy ≥ FIFO_DEPTH-1 after the current cycle's push/pop.

Memory side:
- mem_we_o=1 whenever the FIFO is non-empty. mem_addr_o/mem_din_o show the head entry and hold stable while mem_we_o=1 and mem_ready_i=0.
- A pop occurs on a cycle with mem_we_o & mem_ready_i. The next head is presented the following cycle, so there is 1 cycle of latency from push to mem_we_o.
- Minimum pop spacing is 1 cycle (back-to-back acceptance allowed).

Flags (updated on accepted pushes only, push side, independent of drain):
- Every push: cart_pages_o <= ioctl_addr_i[19:14].
- Push at addr 0: sg1000_o <= (ioctl_index_i[4:0]==2); extram_o <= 0; header_ok_o <= 0; overflow_o <= 0; byte0 is latched.
- Push at addr 1: header_ok_o <= ({byte0,data}==16'hAA55 || {byte0,data}==16'h55AA) && !sg1000_o.
- Push with sg1000_o=1 and addr[ADDR_W-1:13]==1: extram_o <= ((addr[12:0]==0) | extram_o) & (data==8'hFF). A single non-FF byte in the window clears it permanently for this load.

FSM:
- IDLE: ioctl_download_i=1 → LOAD.
- LOAD: ioctl_download_i=0 → DRAIN.
- DRAIN:
  - FIFO empty → DONE.
  - ioctl_download_i=1 → LOAD, keeping the FIFO, which continues draining.
- DONE: load_done_o=1 for this single cycle, then → IDLE, or → LOAD if ioctl_download_i=1.
- Download that drops with an empty FIFO: DRAIN lasts 1 cycle, then DONE.

Test Plan:
- 16-byte Coleco load (AA,55,...), mem_ready_i tied 1 → 16 SDRAM writes in address order; header_ok_o=1, sg1000_o=0, cart_pages_o=0; load_done_o pulses once, 2 cycles after download falls with the FIFO empty.
- Load of 0x8000 bytes, index 2, bytes 0x2000-0x3FFF all FF → sg1000_o=1, extram_o=1, cart_pages_o=1. Repeat with byte 0x3000=0x00 → extram_o=0.
- mem_ready_i=0 while 4 bytes are pushed → ioctl_wait_o=1 after the 3rd push; the 5th byte is dropped with overflow_o=1. Release ready → exactly 4 writes, data unchanged while stalled.
- mem_ready_i toggling every cycle during a 64-byte load → no loss or duplication; mem_addr_o/mem_din_o are stable across every stall cycle.
- Header 55,AA → header_ok_o=1; header 55,55 → 0. A new load at addr 0 clears overflow_o and extram_o.
- reset_n_i low mid-drain → all outputs 0 asynchronously, mem_we_o=0, FSM in IDLE; a subsequent clean load behaves as in the first scenario.
